// File: rtl/ex_mem_stage.sv
// Execute stage: forwarding, ALU and the EX/MEM pipeline register.
// Also raises the load-use stall request back to decode.
module ex_mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_flush,
  input  logic        wb_MemToReg,
  input  logic        wb_RegWrite,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        ex_ALUSrc,
  input  logic        ex_RegDst,
  input  logic [2:0]  ex_ALUOp,
  input  logic [31:0] D1,
  input  logic [31:0] D2,
  input  logic [31:0] immediate,
  input  logic [4:0]  Rs,
  input  logic [4:0]  Rt,
  input  logic [4:0]  Rd,
  input  logic [4:0]  id_Rs,
  input  logic [4:0]  id_Rt,
  input  logic        hold,
  input  logic        wb_wr_en,
  input  logic [4:0]  wb_wr_addr,
  input  logic [31:0] wb_wr_data,
  output logic        load_use_stall,
  output logic        exmem_MemToReg,
  output logic        exmem_RegWrite,
  output logic        exmem_MemRead,
  output logic        exmem_MemWrite,
  output logic [31:0] exmem_alu,
  output logic [31:0] exmem_store,
  output logic [4:0]  exmem_Rd,
  output logic        exmem_zero
);

  logic        r_m2r;
  logic        r_rw;
  logic        r_mr;
  logic        r_mw;
  logic [31:0] r_alu;
  logic [31:0] r_store;
  logic [4:0]  r_rd;
  logic        r_zero;

  logic [4:0]  w_dst;
  logic        w_mem_ok;
  logic        w_wb_ok;
  logic [31:0] w_fwd_a;
  logic [31:0] w_fwd_b;
  logic [31:0] w_opb;
  logic [31:0] w_alu;

  assign w_dst    = ex_RegDst ? Rd : Rt;
  assign w_mem_ok = r_rw && !r_mr && (r_rd != 5'd0);
  assign w_wb_ok  = wb_wr_en && (wb_wr_addr != 5'd0);

  // Operand forwarding, EX/MEM ahead of MEM/WB; loads in EX/MEM never forward
  always_comb begin
    w_fwd_a = D1;
    w_fwd_b = D2;
    if (w_mem_ok && r_rd == Rs)
      w_fwd_a = r_alu;
    else if (w_wb_ok && wb_wr_addr == Rs)
      w_fwd_a = wb_wr_data;
    if (w_mem_ok && r_rd == Rt)
      w_fwd_b = r_alu;
    else if (w_wb_ok && wb_wr_addr == Rt)
      w_fwd_b = wb_wr_data;
  end

  assign w_opb = ex_ALUSrc ? immediate : w_fwd_b;

  // ALU datapath
  always_comb begin
    w_alu = 32'd0;
    unique case (ex_ALUOp)
      3'b000: w_alu = w_fwd_a + w_opb;
      3'b001: w_alu = w_fwd_a - w_opb;
      3'b010: w_alu = w_fwd_a & w_opb;
      3'b011: w_alu = w_fwd_a | w_opb;
      3'b100: w_alu = {31'd0, $signed(w_fwd_a) < $signed(w_opb)};
      3'b101: w_alu = ~(w_fwd_a | w_opb);
      3'b110: w_alu = w_fwd_a ^ w_opb;
      3'b111: w_alu = w_opb;
      default: w_alu = 32'd0;
    endcase
  end

  assign load_use_stall = MemRead && (Rt != 5'd0) &&
                          (Rt == id_Rs || Rt == id_Rt);

  // EX/MEM register: reset, then hold, then flush-as-bubble, then load
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_m2r   <= 1'b0;
      r_rw    <= 1'b0;
      r_mr    <= 1'b0;
      r_mw    <= 1'b0;
      r_alu   <= 32'd0;
      r_store <= 32'd0;
      r_rd    <= 5'd0;
      r_zero  <= 1'b0;
    end else if (!hold) begin
      r_m2r   <= if_flush ? 1'b0 : wb_MemToReg;
      r_rw    <= if_flush ? 1'b0 : wb_RegWrite;
      r_mr    <= if_flush ? 1'b0 : MemRead;
      r_mw    <= if_flush ? 1'b0 : MemWrite;
      r_alu   <= w_alu;
      r_store <= w_fwd_b;
      r_rd    <= w_dst;
      r_zero  <= (w_alu == 32'd0);
    end
  end

  assign exmem_MemToReg = r_m2r;
  assign exmem_RegWrite = r_rw;
  assign exmem_MemRead  = r_mr;
  assign exmem_MemWrite = r_mw;
  assign exmem_alu      = r_alu;
  assign exmem_store    = r_store;
  assign exmem_Rd       = r_rd;
  assign exmem_zero     = r_zero;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage.
// Inputs change just after a rising edge; outputs are sampled there too.
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_flush;
  logic        wb_MemToReg, wb_RegWrite, MemRead, MemWrite;
  logic        ex_ALUSrc, ex_RegDst;
  logic [2:0]  ex_ALUOp;
  logic [31:0] D1, D2, immediate;
  logic [4:0]  Rs, Rt, Rd, id_Rs, id_Rt;
  logic        hold, wb_wr_en;
  logic [4:0]  wb_wr_addr;
  logic [31:0] wb_wr_data;
  logic        load_use_stall;
  logic        exmem_MemToReg, exmem_RegWrite;
  logic        exmem_MemRead, exmem_MemWrite;
  logic [31:0] exmem_alu, exmem_store;
  logic [4:0]  exmem_Rd;
  logic        exmem_zero;

  int checks = 0;
  int failures = 0;

  ex_mem_stage dut (
    .clk(clk), .rst(rst), .if_flush(if_flush),
    .wb_MemToReg(wb_MemToReg), .wb_RegWrite(wb_RegWrite),
    .MemRead(MemRead), .MemWrite(MemWrite),
    .ex_ALUSrc(ex_ALUSrc), .ex_RegDst(ex_RegDst),
    .ex_ALUOp(ex_ALUOp), .D1(D1), .D2(D2), .immediate(immediate),
    .Rs(Rs), .Rt(Rt), .Rd(Rd), .id_Rs(id_Rs), .id_Rt(id_Rt),
    .hold(hold), .wb_wr_en(wb_wr_en), .wb_wr_addr(wb_wr_addr),
    .wb_wr_data(wb_wr_data), .load_use_stall(load_use_stall),
    .exmem_MemToReg(exmem_MemToReg), .exmem_RegWrite(exmem_RegWrite),
    .exmem_MemRead(exmem_MemRead), .exmem_MemWrite(exmem_MemWrite),
    .exmem_alu(exmem_alu), .exmem_store(exmem_store),
    .exmem_Rd(exmem_Rd), .exmem_zero(exmem_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic go();
    @(posedge clk);
    #1;
  endtask

  // Plain ALU op writing a register; Rs=1/Rt=2 unless overridden
  task automatic op(input logic [2:0] aop, input logic [31:0] a,
                    input logic [31:0] b, input logic [4:0] d);
    ex_ALUOp = aop; D1 = a; D2 = b; Rd = d;
    Rs = 5'd1; Rt = 5'd2; ex_RegDst = 1'b1; ex_ALUSrc = 1'b0;
    wb_RegWrite = 1'b1; wb_MemToReg = 1'b0;
    MemRead = 1'b0; MemWrite = 1'b0; if_flush = 1'b0; hold = 1'b0;
    wb_wr_en = 1'b0; wb_wr_addr = 5'd0; wb_wr_data = 32'd0;
  endtask

  function automatic logic [31:0] ctl();
    return {28'd0, exmem_MemToReg, exmem_RegWrite,
            exmem_MemRead, exmem_MemWrite};
  endfunction

  initial begin
    rst = 1'b0; immediate = 32'd0; id_Rs = 5'd0; id_Rt = 5'd0;
    op(3'b000, $urandom, $urandom, 5'd9);
    MemWrite = 1'b1; wb_MemToReg = 1'b1;
    go();
    D1 = $urandom; D2 = $urandom;
    go();
    chk("rst_alu", exmem_alu, 32'd0);
    chk("rst_store", exmem_store, 32'd0);
    chk("rst_rd", {27'd0, exmem_Rd}, 32'd0);
    chk("rst_ctl", ctl(), 32'd0);
    chk("rst_zero", {31'd0, exmem_zero}, 32'd0);
    chk("rst_stall", {31'd0, load_use_stall}, 32'd0);

    rst = 1'b1;
    op(3'b000, 32'd5, 32'd7, 5'd3);
    go();
    chk("add_alu", exmem_alu, 32'd12);
    chk("add_zero", {31'd0, exmem_zero}, 32'd0);
    chk("add_rd", {27'd0, exmem_Rd}, 32'd3);
    chk("add_ctl", ctl(), 32'h4);
    chk("add_store", exmem_store, 32'd7);

    op(3'b000, 32'h10, 32'd0, 5'd3);
    go();
    op(3'b001, 32'hFF, 32'h10, 5'd6);
    Rs = 5'd3; Rt = 5'd5;
    go();
    chk("fwdmem_alu", exmem_alu, 32'd0);
    chk("fwdmem_zero", {31'd0, exmem_zero}, 32'd1);

    op(3'b000, 32'hA, 32'd0, 5'd4);
    go();
    op(3'b000, 32'h99, 32'd0, 5'd7);
    Rs = 5'd4;
    wb_wr_en = 1'b1; wb_wr_addr = 5'd4; wb_wr_data = 32'hB;
    go();
    chk("prio_alu", exmem_alu, 32'hA);

    op(3'b000, 32'h20, 32'd0, 5'd0);
    go();
    op(3'b000, 32'h3, 32'd0, 5'd7);
    Rs = 5'd0;
    wb_wr_en = 1'b1; wb_wr_addr = 5'd0; wb_wr_data = 32'hB;
    go();
    chk("reg0_alu", exmem_alu, 32'h3);

    op(3'b000, 32'd1, 32'd100, 5'd7);
    Rt = 5'd9;
    wb_wr_en = 1'b1; wb_wr_addr = 5'd9; wb_wr_data = 32'h50;
    go();
    chk("fwdwb_alu", exmem_alu, 32'h51);
    chk("fwdwb_store", exmem_store, 32'h50);

    op(3'b000, 32'h40, 32'd0, 5'd10);
    MemRead = 1'b1; wb_MemToReg = 1'b1;
    go();
    chk("load_ctl", ctl(), 32'hE);
    op(3'b000, 32'h5, 32'd0, 5'd7);
    Rs = 5'd10;
    go();
    chk("nofwd_load", exmem_alu, 32'h5);

    MemRead = 1'b1; Rt = 5'd8; id_Rs = 5'd8; id_Rt = 5'd0;
    #1;
    chk("lu_rs", {31'd0, load_use_stall}, 32'd1);
    id_Rs = 5'd0; id_Rt = 5'd8;
    #1;
    chk("lu_rt", {31'd0, load_use_stall}, 32'd1);
    Rt = 5'd0; id_Rt = 5'd0;
    #1;
    chk("lu_r0", {31'd0, load_use_stall}, 32'd0);
    Rt = 5'd8; id_Rt = 5'd8; MemRead = 1'b0;
    #1;
    chk("lu_norm", {31'd0, load_use_stall}, 32'd0);
    id_Rt = 5'd0;

    op(3'b000, 32'h1, 32'h1, 5'd12);
    MemWrite = 1'b1; wb_MemToReg = 1'b1; if_flush = 1'b1;
    go();
    chk("flush_ctl", ctl(), 32'd0);

    op(3'b000, 32'h77, 32'd0, 5'd11);
    go();
    op(3'b001, 32'h1, 32'd0, 5'd13);
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      go();
      chk("hold_alu", exmem_alu, 32'h77);
    end
    chk("hold_rd", {27'd0, exmem_Rd}, 32'd11);
    chk("hold_ctl", ctl(), 32'h4);
    if_flush = 1'b1;
    go();
    chk("holdfl_ctl", ctl(), 32'h4);
    chk("holdfl_alu", exmem_alu, 32'h77);
    hold = 1'b0; if_flush = 1'b0;
    go();
    chk("release_alu", exmem_alu, 32'h1);
    chk("release_rd", {27'd0, exmem_Rd}, 32'd13);

    op(3'b100, 32'hFFFFFFFF, 32'd1, 5'd12);
    go();
    chk("slt", exmem_alu, 32'd1);
    op(3'b101, 32'd0, 32'd0, 5'd12);
    go();
    chk("nor", exmem_alu, 32'hFFFFFFFF);
    op(3'b000, 32'd4, 32'h33, 5'd12);
    ex_ALUSrc = 1'b1; immediate = 32'hFFFFFFFC;
    go();
    chk("imm_alu", exmem_alu, 32'd0);
    chk("imm_zero", {31'd0, exmem_zero}, 32'd1);
    chk("imm_store", exmem_store, 32'h33);
    op(3'b001, 32'd0, 32'd1, 5'd12);
    go();
    chk("sub_wrap", exmem_alu, 32'hFFFFFFFF);
    op(3'b010, 32'hF0F0, 32'hFF00, 5'd12);
    go();
    chk("and", exmem_alu, 32'hF000);
    op(3'b011, 32'hF0F0, 32'hFF00, 5'd12);
    go();
    chk("or", exmem_alu, 32'hFFF0);
    op(3'b110, 32'hF0F0, 32'hFF00, 5'd12);
    go();
    chk("xor", exmem_alu, 32'h0FF0);
    op(3'b111, 32'hF0F0, 32'hFF00, 5'd12);
    go();
    chk("passb", exmem_alu, 32'hFF00);
    op(3'b100, 32'd1, 32'hFFFFFFFF, 5'd12);
    go();
    chk("slt_neg", exmem_alu, 32'd0);
    op(3'b000, 32'd3, 32'd4, 5'd5);
    ex_RegDst = 1'b0; Rt = 5'd14;
    go();
    chk("regdst_rt", {27'd0, exmem_Rd}, 32'd14);

    hold = 1'b1; if_flush = 1'b1; rst = 1'b0;
    go();
    chk("midrst_alu", exmem_alu, 32'd0);
    chk("midrst_ctl", ctl(), 32'd0);
    chk("midrst_rd", {27'd0, exmem_Rd}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
